fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Arbitrates the single-port 100×100 framebuffer RAM (10000 words) between three users: the VGA display reader, the game-logic pixel writer and a built-in screen-clear engine. It sits between the VGA scan-address generator and the framebuffer memory. Display reads are never stalled. The writer and the clear engine use the remaining memory cycles.

## Interface
- DEPTH, 10000, number of framebuffer words (100×100).
- ADDR_W, 14, address width.
- DATA_W, 8, pixel word width.
- CLEAR_VAL, 8'h00, value written by the clear engine and returned for out-of-range reads.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  DATA_W  read data.
- disp_valid  out  1  disp_data valid.
- wr_req  in  1  writer request; held high with wr_addr/wr_data stable until granted.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  one-cycle pulse; the write is accepted this cycle.
- wr_oob  out  1  sticky flag; set when a write to addr ≥ DEPTH is granted; cleared only by rst.
- clear_start  in  1  pulse; starts a full-screen clear.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write is issued.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data; synchronous, valid one cycle after mem_addr.

## Operation
- Fixed priority per cycle: display > clear engine > writer.
- Display path:
  - disp_req=1 → next cycle mem_addr=disp_addr, mem_we=0.
  - disp_addr ≥ DEPTH → mem_addr=0, and the returned disp_data is forced to CLEAR_VAL.
- Writer path:
  - Granted only when disp_req=0, clear_busy=0 and wr_req=1.
  - Grant → wr_gnt=1 the same cycle; next cycle mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Granted write with wr_addr ≥ DEPTH → wr_gnt still pulses, mem_we stays 0, wr_oob sets.
- Clear engine FSM, states IDLE and CLEAR:
  - IDLE + clear_start → CLEAR; clear_busy=1 from the next cycle; counter=0.
  - CLEAR, disp_req=0 → write CLEAR_VAL at counter, counter+1.
  - CLEAR, disp_req=1 → counter holds.
  - Write issued with counter=DEPTH-1 → IDLE; clear_done pulses in the following cycle; clear_busy drops in the same cycle clear_done rises.
  - clear_start while in CLEAR → ignored; no restart.
- Simultaneous events:
  - disp_req+wr_req → display served, wr_gnt=0; the writer keeps holding.
  - clear_start+wr_req in the same IDLE cycle → the writer may be granted that cycle; clearing begins the next cycle.
- Reset (including mid-clear): FSM→IDLE, counter=0; all outputs 0 (mem_addr, mem_we, mem_wdata, disp_data, disp_valid, wr_gnt, wr_oob, clear_busy, clear_done). Any in-flight read is discarded (disp_valid=0).
- Counter width: ADDR_W. It never exceeds DEPTH-1 and does not wrap.

## Timing
- Display read latency: 2 cycles. disp_req at cycle N → mem_addr at N+1 → disp_valid=1 and disp_data=mem_rdata (or CLEAR_VAL) at N+2.
- Back-to-back disp_req every cycle is supported at full throughput.
- Write latency: wr_gnt at cycle N → mem_we at N+1.
- Writer handshake: after wr_gnt, the writer may present a new request from N+1.
- Clear duration: exactly DEPTH cycles with no display traffic. Each display cycle adds one cycle.
- No combinational path from any input to mem_*. wr_gnt is combinational from wr_req/disp_req/clear_busy.

## Configuration
- FB_CLEAR_EN defined: clear engine present, as described above.
- FB_CLEAR_EN undefined:
  - Clear engine removed; clear_start ignored.
  - clear_busy and clear_done tied to 0.
  - Writer arbitrates against the display only.
  - Ports unchanged.

## Structure
- Package fb_pkg holds:
  - FB_DEPTH=10000, FB_ADDR_W=14, FB_DATA_W=8, FB_CLEAR_VAL.
  - The clear FSM state enum (CLR_IDLE, CLR_RUN).
- One sub-module: fb_clear_engine.
  - Contains the FSM, the counter and the done pulse.
  - Inputs: clk, rst, start, stall (=disp_req).
  - Outputs: busy, wr_en, addr, done.
  - Instantiated only under FB_CLEAR_EN.

## Test plan
- Reset: assert rst 3 cycles mid-operation → every output 0 the cycle after; disp_valid 0 for an in-flight read.
- Display read: disp_req=1 with addr 0, 9999 and 10005 on consecutive cycles → disp_valid at N+2..N+4; data = RAM[0], RAM[9999], CLEAR_VAL.
- Contention: wr_req held at addr 42/data 8'hA5 while disp_req is high for 5 cycles → wr_gnt=0 for those 5 cycles; wr_gnt=1 the first cycle disp_req=0; RAM[42]=8'hA5; wr_oob stays 0.
- Out of range: granted write to addr 10000 → mem_we stays 0; wr_oob=1 until rst.
- Clear: clear_start with no display traffic → clear_busy for exactly 10000 cycles; all words=CLEAR_VAL; one clear_done pulse; wr_req not granted during the clear.
- Clear under load: disp_req every other cycle during the clear → completion takes 20000 cycles; second clear_start mid-clear ignored; reset at counter=5000 → clear_busy=0, FSM idle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, clear-FSM state type and address helper for the
// framebuffer port arbiter.
package fb_pkg;
    localparam int FB_DEPTH  = 10000;
    localparam int FB_ADDR_W = 14;
    localparam int FB_DATA_W = 8;

    localparam logic [FB_DATA_W-1:0] FB_CLEAR_VAL = 8'h00;
    localparam logic [FB_ADDR_W-1:0] FB_LAST =
        FB_ADDR_W'(FB_DEPTH - 1);

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

    function automatic logic fb_in_range(
        input logic [FB_ADDR_W-1:0] a
    );
        return a < FB_ADDR_W'(FB_DEPTH);
    endfunction
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of display, writer, clear and RAM signals around the arbiter.
// slave = arbiter side, master = users and RAM side.
interface fb_port_arbiter_if;
    import fb_pkg::*;

    logic                 disp_req;
    logic [FB_ADDR_W-1:0] disp_addr;
    logic [FB_DATA_W-1:0] disp_data;
    logic                 disp_valid;
    logic                 wr_req;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [FB_DATA_W-1:0] wr_data;
    logic                 wr_gnt;
    logic                 wr_oob;
    logic                 clear_start;
    logic                 clear_busy;
    logic                 clear_done;
    logic [FB_ADDR_W-1:0] mem_addr;
    logic                 mem_we;
    logic [FB_DATA_W-1:0] mem_wdata;
    logic [FB_DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_req, wr_addr, wr_data,
        input  clear_start, mem_rdata,
        output disp_data, disp_valid, wr_gnt, wr_oob,
        output clear_busy, clear_done, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, wr_req, wr_addr, wr_data,
        output clear_start, mem_rdata,
        input  disp_data, disp_valid, wr_gnt, wr_oob,
        input  clear_busy, clear_done, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_clear_engine.sv
// Full-screen clear sequencer: walks 0..DEPTH-1, pausing whenever the
// display owns the RAM cycle.
module fb_clear_engine
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] addr,
    output logic                 done
);
    clr_state_e           state_q;
    logic [FB_ADDR_W-1:0] cnt_q;
    logic                 done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                CLR_IDLE: begin
                    if (start) begin
                        state_q <= CLR_RUN;
                        cnt_q   <= '0;
                    end
                end
                CLR_RUN: begin
                    if (!stall) begin
                        if (cnt_q == FB_LAST) begin
                            state_q <= CLR_IDLE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy  = (state_q == CLR_RUN);
    assign wr_en = busy & ~stall;
    assign addr  = cnt_q;
    assign done  = done_q;
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display > clear engine > writer.
// The clear engine exists only when FB_CLEAR_EN is defined.
module fb_port_arbiter
    import fb_pkg::*;
(
    input logic               clk,
    input logic               rst,
    fb_port_arbiter_if.slave  bus
);
    logic                 clr_busy;
    logic                 clr_wr;
    logic                 clr_done;
    logic [FB_ADDR_W-1:0] clr_addr;

`ifdef FB_CLEAR_EN
    fb_clear_engine u_clear (
        .clk   (clk),
        .rst   (rst),
        .start (bus.clear_start),
        .stall (bus.disp_req),
        .busy  (clr_busy),
        .wr_en (clr_wr),
        .addr  (clr_addr),
        .done  (clr_done)
    );
`else
    logic unused_clear_start;
    assign unused_clear_start = bus.clear_start;
    assign clr_busy = 1'b0;
    assign clr_wr   = 1'b0;
    assign clr_done = 1'b0;
    assign clr_addr = '0;
`endif

    logic                 wr_gnt;
    logic                 wr_ok;
    logic                 disp_ok;
    logic [FB_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [FB_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                 rd1_q, rd1_oob_q;
    logic                 rd2_q, rd2_oob_q;
    logic                 wr_oob_q;

    assign wr_gnt  = bus.wr_req & ~bus.disp_req & ~clr_busy;
    assign wr_ok   = fb_in_range(bus.wr_addr);
    assign disp_ok = fb_in_range(bus.disp_addr);

    // Conditions are mutually exclusive by construction.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        unique case (1'b1)
            bus.disp_req: begin
                mem_addr_d = disp_ok ? bus.disp_addr : '0;
            end
            clr_wr: begin
                mem_addr_d  = clr_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = FB_CLEAR_VAL;
            end
            wr_gnt: begin
                mem_we_d = wr_ok;
                if (wr_ok) begin
                    mem_addr_d  = bus.wr_addr;
                    mem_wdata_d = bus.wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd1_q       <= 1'b0;
            rd1_oob_q   <= 1'b0;
            rd2_q       <= 1'b0;
            rd2_oob_q   <= 1'b0;
            wr_oob_q    <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rd1_q       <= bus.disp_req;
            rd1_oob_q   <= bus.disp_req & ~disp_ok;
            rd2_q       <= rd1_q;
            rd2_oob_q   <= rd1_oob_q;
            if (wr_gnt && !wr_ok) wr_oob_q <= 1'b1;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.disp_valid = rd2_q;
    assign bus.disp_data  = !rd2_q    ? '0 :
                            rd2_oob_q ? FB_CLEAR_VAL : bus.mem_rdata;
    assign bus.wr_gnt     = wr_gnt;
    assign bus.wr_oob     = wr_oob_q;
    assign bus.clear_busy = clr_busy;
    assign bus.clear_done = clr_done;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter with a behavioural RAM and reference model.
// Clear-engine scenarios run only when FB_CLEAR_EN is defined.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b1;

    fb_port_arbiter_if bus();

    fb_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram   [FB_DEPTH];
    logic [7:0] model [FB_DEPTH];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < FB_DEPTH; i++) ram[i] <= 8'(i * 7 + 3);
        end else if (bus.mem_we && int'(bus.mem_addr) < FB_DEPTH) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= (int'(bus.mem_addr) < FB_DEPTH) ?
                         ram[bus.mem_addr] : 8'h00;
    end

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    rd_t  rdq[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    logic oob_exp = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_idle();
        bus.disp_req    = 1'b0;
        bus.disp_addr   = '0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.clear_start = 1'b0;
    endtask

    function automatic logic [35:0] all_outs();
        return {bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.disp_data,
                bus.disp_valid, bus.wr_gnt, bus.wr_oob,
                bus.clear_busy, bus.clear_done};
    endfunction

    function automatic logic [13:0] pick_addr();
        if ($urandom % 4 == 0) return 14'($urandom_range(9995, 10010));
        return 14'($urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        drive_idle();
        for (int i = 0; i < FB_DEPTH; i++) model[i] = 8'(i * 7 + 3);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            ram_init = 1'b0;
            total++;
            if (all_outs() !== 36'h0)
                $display("FAIL reset_outs: got %h want 0", all_outs());
            else passed++;
        end
        rst = 1'b0;
        step();
        total++;
        if (all_outs() !== 36'h0)
            $display("FAIL reset_release: got %h want 0", all_outs());
        else passed++;
    endtask

    task automatic test_display();
        logic [13:0] a [3];
        logic [7:0]  e [3];
        logic [13:0] ma;
        a[0] = 14'd0;
        a[1] = 14'd9999;
        a[2] = 14'd10005;
        e[0] = model[0];
        e[1] = model[9999];
        e[2] = FB_CLEAR_VAL;
        for (int c = 0; c < 6; c++) begin
            bus.disp_req  = (c < 3);
            bus.disp_addr = (c < 3) ? a[c] : 14'd0;
            if (c >= 1 && c <= 3) begin
                ma = (int'(a[c-1]) >= FB_DEPTH) ? 14'd0 : a[c-1];
                total++;
                if (bus.mem_addr !== ma || bus.mem_we !== 1'b0)
                    $display("FAIL disp_mem_addr: got %0d/%b want %0d/0",
                             bus.mem_addr, bus.mem_we, ma);
                else passed++;
            end
            if (c >= 2 && c <= 4) begin
                total++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== e[c-2])
                    $display("FAIL disp_read%0d: got %b/%h want 1/%h",
                             c - 2, bus.disp_valid, bus.disp_data, e[c-2]);
                else passed++;
            end
            if (c == 5) begin
                total++;
                if (bus.disp_valid !== 1'b0)
                    $display("FAIL disp_idle: got %b want 0",
                             bus.disp_valid);
                else passed++;
            end
            step();
        end
        drive_idle();
    endtask

    task automatic test_contention();
        bus.wr_req    = 1'b1;
        bus.wr_addr   = 14'd42;
        bus.wr_data   = 8'hA5;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 14'd100;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bus.wr_gnt !== 1'b0)
                $display("FAIL cont_block%0d: got %b want 0",
                         i, bus.wr_gnt);
            else passed++;
            step();
        end
        bus.disp_req = 1'b0;
        #1;
        total++;
        if (bus.wr_gnt !== 1'b1)
            $display("FAIL cont_grant: got %b want 1", bus.wr_gnt);
        else passed++;
        step();
        bus.wr_req = 1'b0;
        model[42] = 8'hA5;
        total++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 14'd42, 8'hA5})
            $display("FAIL cont_mem: got %b/%0d/%h want 1/42/a5",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else passed++;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 14'd42;
        step();
        bus.disp_req = 1'b0;
        step();
        total++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== model[42])
            $display("FAIL cont_readback: got %b/%h want 1/%h",
                     bus.disp_valid, bus.disp_data, model[42]);
        else passed++;
        total++;
        if (bus.wr_oob !== 1'b0)
            $display("FAIL cont_oob: got %b want 0", bus.wr_oob);
        else passed++;
        drive_idle();
        step();
    endtask

    task automatic test_oob();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 14'd10000;
        bus.wr_data = 8'h77;
        #1;
        total++;
        if (bus.wr_gnt !== 1'b1)
            $display("FAIL oob_grant: got %b want 1", bus.wr_gnt);
        else passed++;
        step();
        bus.wr_req = 1'b0;
        oob_exp = 1'b1;
        total++;
        if (bus.mem_we !== 1'b0)
            $display("FAIL oob_we: got %b want 0", bus.mem_we);
        else passed++;
        repeat (3) step();
        total++;
        if (bus.wr_oob !== 1'b1)
            $display("FAIL oob_sticky: got %b want 1", bus.wr_oob);
        else passed++;
    endtask

    task automatic test_random();
        logic        gnt_prev = 1'b0;
        logic [13:0] pa = '0;
        logic [7:0]  pd = '0;
        logic        fresh = 1'b1;
        logic        exp_g;
        rd_t         r;
        drive_idle();
        for (int c = 0; c < 3000; c++) begin
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                total++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== r.data)
                    $display("FAIL rnd_read c%0d: got %b/%h want 1/%h",
                             c, bus.disp_valid, bus.disp_data, r.data);
                else passed++;
            end else begin
                total++;
                if (bus.disp_valid !== 1'b0)
                    $display("FAIL rnd_novalid c%0d: got %b want 0",
                             c, bus.disp_valid);
                else passed++;
            end
            total++;
            if (bus.wr_oob !== oob_exp)
                $display("FAIL rnd_oob c%0d: got %b want %b",
                         c, bus.wr_oob, oob_exp);
            else passed++;
            total++;
            if (gnt_prev ? ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
                            {1'b1, pa, pd})
                         : (bus.mem_we !== 1'b0))
                $display("FAIL rnd_mem c%0d: got %b/%0d/%h want %b/%0d/%h",
                         c, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                         gnt_prev, pa, pd);
            else passed++;

            bus.disp_req  = 1'($urandom % 2);
            bus.disp_addr = pick_addr();
            if (fresh) begin
                bus.wr_req  = ($urandom % 3 != 0);
                bus.wr_addr = pick_addr();
                bus.wr_data = 8'($urandom);
            end
            #1;
            exp_g = bus.wr_req && !bus.disp_req;
            total++;
            if (bus.wr_gnt !== exp_g)
                $display("FAIL rnd_gnt c%0d: got %b want %b",
                         c, bus.wr_gnt, exp_g);
            else passed++;

            if (bus.disp_req)
                rdq.push_back('{cyc + 2,
                    (int'(bus.disp_addr) < FB_DEPTH) ?
                    model[bus.disp_addr] : FB_CLEAR_VAL});
            gnt_prev = 1'b0;
            fresh = !bus.wr_req || exp_g;
            if (exp_g) begin
                if (int'(bus.wr_addr) < FB_DEPTH) begin
                    model[bus.wr_addr] = bus.wr_data;
                    gnt_prev = 1'b1;
                    pa = bus.wr_addr;
                    pd = bus.wr_data;
                end else begin
                    oob_exp = 1'b1;
                end
            end
            step();
        end
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                total++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== r.data)
                    $display("FAIL rnd_drain: got %b/%h want 1/%h",
                             bus.disp_valid, bus.disp_data, r.data);
                else passed++;
            end
            step();
        end
        total++;
        if (rdq.size() != 0)
            $display("FAIL rnd_leftover: got %0d want 0", rdq.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        drive_idle();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 14'd3;
        step();
        bus.disp_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (all_outs() !== 36'h0)
                $display("FAIL rstmid_outs%0d: got %h want 0",
                         i, all_outs());
            else passed++;
        end
        rst = 1'b0;
        oob_exp = 1'b0;
        step();
        total++;
        if (bus.disp_valid !== 1'b0 || bus.wr_oob !== oob_exp)
            $display("FAIL rstmid_after: got %b/%b want 0/0",
                     bus.disp_valid, bus.wr_oob);
        else passed++;
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        int busy = 0, dones = 0, bad = 0, left = 0;
        logic fin = 1'b0;
        drive_idle();
        bus.clear_start = 1'b1;
        bus.wr_req      = 1'b1;
        bus.wr_addr     = 14'd5;
        bus.wr_data     = 8'h11;
        #1;
        total++;
        if (bus.wr_gnt !== 1'b1)
            $display("FAIL clr_same_gnt: got %b want 1", bus.wr_gnt);
        else passed++;
        step();
        bus.clear_start = 1'b0;
        bus.wr_addr     = 14'd7;
        bus.wr_data     = 8'h22;
        for (int i = 0; i < 12000 && !fin; i++) begin
            if (bus.clear_busy) begin
                busy++;
                if (bus.wr_gnt) bad++;
            end
            if (bus.clear_done) begin
                dones++;
                fin = 1'b1;
            end
            step();
        end
        total++;
        if (busy != FB_DEPTH || dones != 1 || bad != 0)
            $display("FAIL clr_run: busy %0d done %0d gnt %0d want %0d/1/0",
                     busy, dones, bad, FB_DEPTH);
        else passed++;
        bus.wr_req = 1'b0;
        repeat (3) step();
        for (int i = 0; i < FB_DEPTH; i++)
            if (i != 7 && ram[i] !== FB_CLEAR_VAL) left++;
        total++;
        if (left != 0 || ram[7] !== 8'h22)
            $display("FAIL clr_contents: got %0d dirty, [7]=%h want 0/22",
                     left, ram[7]);
        else passed++;
    endtask

    task automatic test_clear_load();
        int busy = 0, dones = 0;
        logic fin = 1'b0;
        drive_idle();
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 25000 && !fin; i++) begin
            bus.disp_req    = 1'b0;
            bus.clear_start = 1'b0;
            if (bus.clear_busy) begin
                bus.disp_req    = (busy % 2 == 0);
                bus.disp_addr   = 14'($urandom_range(0, 9999));
                bus.clear_start = (busy == 7000);
                busy++;
            end
            if (bus.clear_done) begin
                dones++;
                fin = 1'b1;
            end
            step();
        end
        drive_idle();
        total++;
        if (busy != 2 * FB_DEPTH || dones != 1)
            $display("FAIL clr_load: busy %0d done %0d want %0d/1",
                     busy, dones, 2 * FB_DEPTH);
        else passed++;
    endtask

    task automatic test_clear_reset();
        drive_idle();
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        repeat (5000) step();
        total++;
        if (bus.clear_busy !== 1'b1)
            $display("FAIL clrrst_busy: got %b want 1", bus.clear_busy);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0)
            $display("FAIL clrrst_idle: got %b/%b want 0/0",
                     bus.clear_busy, bus.clear_done);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.clear_busy !== 1'b0 || bus.mem_we !== 1'b0)
                $display("FAIL clrrst_stay%0d: got %b/%b want 0/0",
                         i, bus.clear_busy, bus.mem_we);
            else passed++;
        end
    endtask
`else
    task automatic test_no_clear();
        drive_idle();
        bus.clear_start = 1'b1;
        bus.wr_req      = 1'b1;
        bus.wr_addr     = 14'd9;
        bus.wr_data     = 8'h5A;
        #1;
        total++;
        if (bus.wr_gnt !== 1'b1)
            $display("FAIL noclr_gnt0: got %b want 1", bus.wr_gnt);
        else passed++;
        step();
        bus.clear_start = 1'b0;
        bus.wr_addr     = 14'd10;
        bus.wr_data     = 8'h5B;
        #1;
        total++;
        if (bus.wr_gnt !== 1'b1)
            $display("FAIL noclr_gnt1: got %b want 1", bus.wr_gnt);
        else passed++;
        step();
        bus.wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0)
                $display("FAIL noclr_flags%0d: got %b/%b want 0/0",
                         i, bus.clear_busy, bus.clear_done);
            else passed++;
            step();
        end
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_display();
        test_contention();
        test_oob();
        test_random();
        test_reset_mid();
`ifdef FB_CLEAR_EN
        test_clear();
        test_clear_load();
        test_clear_reset();
`else
        test_no_clear();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
